// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default parameters for the PWM duty ramp controller.
// Optional abort support in the top is enabled by defining PWM_CTRL_ABORT_EN.
package pwm_ctrl_pkg;

   localparam int DUTY_W_DEF    = 4;
   localparam int DUTY_MAX_DEF  = 10;
   localparam int DUTY_INIT_DEF = 5;
   localparam int RAMP_DIV_DEF  = 4;

   typedef logic [DUTY_W_DEF-1:0] duty_t;

   typedef enum logic [1:0] {
      IDLE,
      RAMP_UP,
      RAMP_DOWN
   } state_t;

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Absolute duty-target command port (valid/ready) of the PWM duty ramp controller.
interface pwm_duty_ramp_ctrl_if
   import pwm_ctrl_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF
);
   logic              cmd_valid;
   logic [DUTY_W-1:0] cmd_duty;
   logic              cmd_ready;

   modport master (output cmd_valid, output cmd_duty, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_prescaler.sv
// Counts period_end pulses during a ramp and emits step_tick every RAMP_DIV periods.
module pwm_ramp_prescaler
   import pwm_ctrl_pkg::*;
#(
   parameter int RAMP_DIV = RAMP_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic period_end,
   input  logic en,
   input  logic load,
   input  logic clear,
   output logic step_tick
);
   localparam logic [3:0] LAST = 4'(RAMP_DIV - 1);

   logic [3:0] div_cnt;

   assign step_tick = en & period_end & (div_cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (clear) begin
         div_cnt <= '0;
      end else if (load) begin
         div_cnt <= LAST;
      end else if (en && period_end) begin
         div_cnt <= step_tick ? 4'd0 : div_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Owns the live PWM duty and ramps it one step per RAMP_DIV periods toward the target.
// Define PWM_CTRL_ABORT_EN to add the abort input that freezes a ramp at its current duty.
module pwm_duty_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int DUTY_W    = DUTY_W_DEF,
   parameter int DUTY_MAX  = DUTY_MAX_DEF,
   parameter int DUTY_INIT = DUTY_INIT_DEF,
   parameter int RAMP_DIV  = RAMP_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              period_end,
   input  logic              inc_pulse,
   input  logic              dec_pulse,
`ifdef PWM_CTRL_ABORT_EN
   input  logic              abort,
`endif
   pwm_duty_ramp_ctrl_if.slave cmd,
   output logic [DUTY_W-1:0] duty_out,
   output logic              busy,
   output logic              sat
);
   localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(DUTY_INIT);

   state_t            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic              sat_d;
   logic              cnt_load, cnt_clear, step_tick;

   pwm_ramp_prescaler #(.RAMP_DIV(RAMP_DIV)) u_prescaler (
      .clk        (clk),
      .rst        (rst),
      .period_end (period_end),
      .en         (busy),
      .load       (cnt_load),
      .clear      (cnt_clear),
      .step_tick  (step_tick)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      duty_d    = duty_q;
      target_d  = target_q;
      sat_d     = 1'b0;
      cnt_load  = 1'b0;
      cnt_clear = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               cnt_clear = 1'b1;
               if (cmd.cmd_duty > MAX_D) begin
                  target_d = MAX_D;
                  sat_d    = 1'b1;
               end else begin
                  target_d = cmd.cmd_duty;
               end
               if (target_d > duty_q)      state_d = RAMP_UP;
               else if (target_d < duty_q) state_d = RAMP_DOWN;
            end else if (inc_pulse && !dec_pulse) begin
               if (duty_q < MAX_D) begin
                  target_d = duty_q + 1'b1;
                  cnt_load = 1'b1;
                  state_d  = RAMP_UP;
               end else begin
                  sat_d = 1'b1;
               end
            end else if (dec_pulse && !inc_pulse) begin
               if (duty_q != '0) begin
                  target_d = duty_q - 1'b1;
                  cnt_load = 1'b1;
                  state_d  = RAMP_DOWN;
               end else begin
                  sat_d = 1'b1;
               end
            end
         end
         RAMP_UP, RAMP_DOWN: begin
`ifdef PWM_CTRL_ABORT_EN
            if (abort) begin
               target_d  = duty_q;
               cnt_clear = 1'b1;
               state_d   = IDLE;
            end else
`endif
            if (step_tick) begin
               duty_d = (state_q == RAMP_UP) ? duty_q + 1'b1 : duty_q - 1'b1;
               if (duty_d == target_q) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         duty_q   <= INIT_D;
         target_q <= INIT_D;
         sat      <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         sat      <= sat_d;
      end
   end

   assign duty_out      = duty_q;
   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed self-checking bench for pwm_duty_ramp_ctrl; period_end every 10 cycles.
module tb_pwm_duty_ramp_ctrl;
   import pwm_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst, period_end, inc_pulse, dec_pulse;
`ifdef PWM_CTRL_ABORT_EN
   logic abort;
`endif
   duty_t duty_out;
   logic  busy, sat;
   int    n_checks = 0;
   int    n_errors = 0;

   pwm_duty_ramp_ctrl_if #(.DUTY_W(DUTY_W_DEF)) cmd_if ();

   pwm_duty_ramp_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .period_end (period_end),
      .inc_pulse  (inc_pulse),
      .dec_pulse  (dec_pulse),
`ifdef PWM_CTRL_ABORT_EN
      .abort      (abort),
`endif
      .cmd        (cmd_if),
      .duty_out   (duty_out),
      .busy       (busy),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // n PWM periods; returns at the negedge after the n-th period_end edge.
   task automatic periods(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (9) @(negedge clk);
         period_end = 1'b1;
         @(negedge clk);
         period_end = 1'b0;
      end
   endtask

   task automatic send_cmd(input int d);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 4'(d);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic expect_state(input string tag, input int d, input int b);
      check({tag, "_duty"}, int'(duty_out), d);
      check({tag, "_busy"}, int'(busy), b);
      check({tag, "_ready"}, int'(cmd_if.cmd_ready), 1 - b);
   endtask

   initial begin
      rst = 1'b1; period_end = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_duty = '0;
`ifdef PWM_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      expect_state("reset", 5, 0);
      check("reset_sat", int'(sat), 0);
      rst = 1'b0;
      @(negedge clk);

      // Ramp 5 -> 8
      send_cmd(8);
      expect_state("up8_accept", 5, 1);
      check("up8_sat", int'(sat), 0);
      periods(3);
      expect_state("up8_pe3", 5, 1);
      periods(1);
      expect_state("up8_pe4", 6, 1);
      periods(4);
      expect_state("up8_pe8", 7, 1);
      periods(4);
      expect_state("up8_pe12", 8, 0);

      // Asynchronous reset in the middle of a ramp down, checked before any clock edge
      send_cmd(0);
      periods(4);
      expect_state("dn0_pe4", 7, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 expect_state("async_rst", 5, 0);
      @(negedge clk);
      rst = 1'b0;

      // Clamped command 13 -> 10
      send_cmd(13);
      check("clamp_sat", int'(sat), 1);
      check("clamp_busy", int'(busy), 1);
      @(negedge clk);
      check("clamp_sat_once", int'(sat), 0);
      periods(19);
      expect_state("clamp_pe19", 9, 1);
      periods(1);
      expect_state("clamp_pe20", 10, 0);

      // Buttons at the upper limit
      inc_pulse = 1'b1;
      @(negedge clk);
      inc_pulse = 1'b0;
      check("inc_max_sat", int'(sat), 1);
      expect_state("inc_max", 10, 0);
      dec_pulse = 1'b1;
      @(negedge clk);
      dec_pulse = 1'b0;
      check("dec_sat", int'(sat), 0);
      expect_state("dec_accept", 10, 1);
      periods(1);
      expect_state("dec_pe1", 9, 0);

      // Command beats a coincident inc; inc during ramp is dropped
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_duty = 4'd2; inc_pulse = 1'b1;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0; inc_pulse = 1'b0;
      expect_state("cmd_vs_inc", 9, 1);
      periods(4);
      expect_state("cmd2_pe4", 8, 1);
      inc_pulse = 1'b1;
      @(negedge clk);
      inc_pulse = 1'b0;
      expect_state("inc_in_ramp", 8, 1);
      periods(24);
      expect_state("cmd2_done", 2, 0);

      // inc+dec together is ignored; period_end in IDLE has no effect
      inc_pulse = 1'b1; dec_pulse = 1'b1;
      @(negedge clk);
      inc_pulse = 1'b0; dec_pulse = 1'b0;
      check("both_sat", int'(sat), 0);
      expect_state("both_btn", 2, 0);
      periods(1);
      expect_state("idle_pe", 2, 0);

      // Command equal to current duty: no busy pulse
      send_cmd(2);
      expect_state("cmd_equal", 2, 0);

      // Ramp to 0 then dec at the lower limit
      send_cmd(0);
      periods(8);
      expect_state("dn_to0", 0, 0);
      dec_pulse = 1'b1;
      @(negedge clk);
      dec_pulse = 1'b0;
      check("dec_min_sat", int'(sat), 1);
      expect_state("dec_min", 0, 0);

`ifdef PWM_CTRL_ABORT_EN
      send_cmd(5);
      periods(20);
      expect_state("ab_pre", 5, 0);
      send_cmd(9);
      periods(4);
      expect_state("ab_step", 6, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      expect_state("ab_idle", 6, 0);
      periods(4);
      expect_state("ab_hold", 6, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
